// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the CPU data port: one request in flight,
// fixed LATENCY from acceptance to a one-cycle response strobe, range/alignment checked.
module data_mem_responder #(
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        busy_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [DEPTH];

  logic             enter_resp;
  logic             src_write;
  logic [31:0]      src_addr;
  logic [31:0]      src_wdata;
  logic             src_err;
  logic [IDX_W-1:0] src_idx;
  logic             mem_we;

  // With LATENCY = 1 the response is formed straight from the request inputs,
  // since the latched copy is not available until the following edge.
  always_comb begin
    enter_resp = ((state == IDLE) && req_valid_i && (LATENCY == 1))
              || ((state == WAIT) && (cnt == 4'd1));
    src_write  = (state == IDLE) ? req_write_i : lat_write;
    src_addr   = (state == IDLE) ? req_addr_i  : lat_addr;
    src_wdata  = (state == IDLE) ? req_wdata_i : lat_wdata;
    src_err    = (src_addr[1:0] != 2'b00) || (src_addr[31:2] >= 30'(DEPTH));
    src_idx    = src_addr[IDX_W+1:2];
    mem_we     = enter_resp && !src_err && src_write;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      assert (LATENCY >= 1 && LATENCY <= 15)
        else $error("data_mem_responder: LATENCY %0d outside 1..15", LATENCY);
      rdata_q <= '0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            lat_write <= req_write_i;
            lat_addr  <= req_addr_i;
            lat_wdata <= req_wdata_i;
            cnt       <= 4'(LATENCY - 1);
            state     <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        err_q <= src_err;
        if (!src_err && !src_write) rdata_q <= mem[src_idx];
      end
    end
  end

  // One register per word so the reset clear and the single write port stay simple.
  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_word
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        mem[g] <= '0;
      end else if (mem_we && (src_idx == IDX_W'(g))) begin
        mem[g] <= src_wdata;
      end
    end
  end

  assign req_ready_o  = (state == IDLE);
  assign resp_valid_o = (state == RESP);
  assign busy_o       = ~req_ready_o;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY 2 and 1) checked cycle by
// cycle against a word-array reference model; outputs sampled on the falling edge.
module tb_data_mem_responder;

  logic        clk;
  logic [1:0]  rst, valid, write, ready, rvalid, err, busy;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  logic [31:0] mdl [2][128];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(128), .LATENCY(2)) dut_l2 (
    .clk_i(clk), .rst_i(rst[0]), .req_valid_i(valid[0]), .req_ready_o(ready[0]),
    .req_write_i(write[0]), .req_addr_i(addr[0]), .req_wdata_i(wdata[0]),
    .resp_valid_o(rvalid[0]), .resp_rdata_o(rdata[0]), .resp_err_o(err[0]),
    .busy_o(busy[0])
  );

  data_mem_responder #(.DEPTH(128), .LATENCY(1)) dut_l1 (
    .clk_i(clk), .rst_i(rst[1]), .req_valid_i(valid[1]), .req_ready_o(ready[1]),
    .req_write_i(write[1]), .req_addr_i(addr[1]), .req_wdata_i(wdata[1]),
    .resp_valid_o(rvalid[1]), .resp_rdata_o(rdata[1]), .resp_err_o(err[1]),
    .busy_o(busy[1])
  );

  function automatic int lat(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic model_reset(input int d);
    for (int i = 0; i < 128; i++) mdl[d][i] = '0;
  endtask

  // Reference behaviour: bad alignment or word index >= 128 is an error with no effect.
  task automatic model_apply(input int d, input bit w, input logic [31:0] a,
                             input logic [31:0] wd, output bit e, output logic [31:0] rd);
    e  = (a[1:0] != 2'b00) || (a[31:2] >= 30'd128);
    rd = '0;
    if (!e) begin
      if (w) mdl[d][int'(a[31:2])] = wd;
      else   rd = mdl[d][int'(a[31:2])];
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 6)       return 32'($urandom_range(0, 15)) << 2;
    else if (r < 8)  return (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(1, 3));
    else if (r == 8) return ($urandom_range(0, 1) == 1) ? 32'h0000_01FC : 32'h0000_0200;
    else             return 32'($urandom_range(128, 4096)) << 2;
  endfunction

  // Called on a falling edge (cycle 0); returns on the falling edge of cycle L+1.
  task automatic do_req(input int d, input bit w, input logic [31:0] a,
                        input logic [31:0] wd, input string tag);
    bit          e;
    logic [31:0] rd;
    int          l;
    l = lat(d);
    check({tag, "/ready"}, 32'(ready[d]), 32'd1);
    check({tag, "/idle_rv"}, 32'(rvalid[d]), 32'd0);
    valid[d] = 1'b1; write[d] = w; addr[d] = a; wdata[d] = wd;
    model_apply(d, w, a, wd, e, rd);
    for (int k = 1; k <= l; k++) begin
      @(negedge clk);
      if (k == 1) begin
        valid[d] = 1'b0;
        addr[d]  = $urandom;
        wdata[d] = $urandom;
      end
      check({tag, "/rv"}, 32'(rvalid[d]), 32'(k == l));
      check({tag, "/busy"}, 32'(busy[d]), 32'd1);
      if (k == l) begin
        check({tag, "/err"}, 32'(err[d]), 32'(e));
        check({tag, "/rdata"}, rdata[d], rd);
      end
    end
    @(negedge clk);
  endtask

  // Request held valid every cycle: acceptances only at multiples of L+1.
  task automatic busy_hold(input int d);
    int          l;
    bit          pe;
    logic [31:0] prd;
    l = lat(d);
    pe = 1'b0; prd = '0;
    for (int c = 0; c < 4 * (l + 1); c++) begin
      check("hold/rv", 32'(rvalid[d]), 32'((c % (l + 1)) == l));
      check("hold/ready", 32'(ready[d]), 32'((c % (l + 1)) == 0));
      if ((c % (l + 1)) == l) begin
        check("hold/err", 32'(err[d]), 32'(pe));
        check("hold/rdata", rdata[d], prd);
      end
      valid[d] = 1'b1;
      write[d] = 1'($urandom_range(0, 1));
      addr[d]  = (c % 2 == 1) ? 32'h24 : 32'h20;
      wdata[d] = $urandom;
      if ((c % (l + 1)) == 0) model_apply(d, write[d], addr[d], wdata[d], pe, prd);
      @(negedge clk);
    end
    valid[d] = 1'b0;
  endtask

  initial begin
    rst = '1; valid = '1; write = '1;
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0; wdata[d] = 32'hFFFF_FFFF;
    end

    // Reset held two cycles with a request presented
    repeat (2) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check("rst/ready", 32'(ready[d]), 32'd1);
        check("rst/rv", 32'(rvalid[d]), 32'd0);
        check("rst/busy", 32'(busy[d]), 32'd0);
        check("rst/err", 32'(err[d]), 32'd0);
        check("rst/rdata", rdata[d], 32'd0);
      end
    end
    rst = '0; valid = '0; write = '0;
    for (int d = 0; d < 2; d++) model_reset(d);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("post_rst/ready", 32'(ready[d]), 32'd1);
      do_req(d, 1'b0, 32'h0, 32'h0, "post_rst/load0");
    end

    // LATENCY 2: store then back-to-back load, then error cases
    do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, "l2/st10");
    do_req(0, 1'b0, 32'h10, 32'h0, "l2/ld10");
    do_req(0, 1'b1, 32'h0, 32'hCAFE_F00D, "l2/st0");
    do_req(0, 1'b0, 32'h13, 32'h0, "l2/ld13_err");
    do_req(0, 1'b1, 32'h200, 32'h1111_2222, "l2/st200_err");
    do_req(0, 1'b0, 32'h0, 32'h0, "l2/ld0");
    do_req(0, 1'b1, 32'h1FC, 32'h0BAD_CAFE, "l2/st1fc");
    do_req(0, 1'b0, 32'h1FC, 32'h0, "l2/ld1fc");

    // LATENCY 1: back-to-back store/load
    do_req(1, 1'b1, 32'h8, 32'h0000_00A5, "l1/st8");
    do_req(1, 1'b0, 32'h8, 32'h0, "l1/ld8");

    for (int d = 0; d < 2; d++) begin
      busy_hold(d);
      do_req(d, 1'b0, 32'h20, 32'h0, "hold/ld20");
      do_req(d, 1'b0, 32'h24, 32'h0, "hold/ld24");
    end

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 30; i++)
        do_req(d, 1'($urandom_range(0, 1)), rand_addr(), $urandom, "rand");

    // Reset on the edge that would enter RESP and commit the store
    do_req(0, 1'b1, 32'h4, 32'h5555_AAAA, "mid/pre_st4");
    valid[0] = 1'b1; write[0] = 1'b1; addr[0] = 32'h4; wdata[0] = 32'h1234_5678;
    @(negedge clk);
    valid[0] = 1'b0; rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    model_reset(0);
    repeat (3) begin
      check("mid/rv", 32'(rvalid[0]), 32'd0);
      check("mid/ready", 32'(ready[0]), 32'd1);
      @(negedge clk);
    end
    do_req(0, 1'b0, 32'h4, 32'h0, "mid/ld4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
